// File: rtl/alu_ops_pkg.sv
// Shared ALU function codes and the divider FSM state type, used by the
// multiplier, divider and ALU decoder.
package alu_ops_pkg;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] OUT   = 6'b111111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

endpackage

// File: rtl/divider_if.sv
// Operand/function-code/result bundle between the ALU datapath and the divider.
interface divider_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   dataA;
  logic [WIDTH-1:0]   dataB;
  logic [5:0]         Signal;
  logic [2*WIDTH-1:0] dataOut;
  logic               busy;
  logic               done;

  modport master (output dataA, dataB, Signal, input dataOut, busy, done);
  modport slave  (input dataA, dataB, Signal, output dataOut, busy, done);
endinterface

// File: rtl/divider_step.sv
// One combinational restoring-division iteration: shift {rem, quo} left,
// try to subtract the divisor, keep the difference when it does not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH:0] shifted;

  // The remainder after a successful subtract is below the divisor, so the
  // low WIDTH bits of the difference are exact.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    if (shifted >= {1'b0, divisor}) begin
      rem_next = shifted[WIDTH-1:0] - divisor;
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/divider.sv
// Sequential radix-2 restoring divider, one quotient bit per clock, result
// {remainder, quotient}. Signed DIV support is enabled by DIVIDER_SIGNED_EN.
module divider
  import alu_ops_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  divider_if.slave bus
);
  div_state_t state, state_next;

  logic [WIDTH-1:0]   rem, quo, divisor;
  logic [5:0]         count;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   rem_step, quo_step;
  logic [WIDTH-1:0]   dividend_mag, divisor_mag;
  logic [WIDTH-1:0]   quo_final, rem_final;
  logic               start, last;

  assign last = (count == 6'(WIDTH - 1));

`ifdef DIVIDER_SIGNED_EN
  logic signed_op, neg_quo, neg_rem;

  assign signed_op    = (bus.Signal == DIV);
  assign start        = (bus.Signal == DIVU) || signed_op;
  assign dividend_mag = (signed_op && bus.dataA[WIDTH-1]) ? -bus.dataA : bus.dataA;
  assign divisor_mag  = (signed_op && bus.dataB[WIDTH-1]) ? -bus.dataB : bus.dataB;

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_quo <= signed_op && (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
      neg_rem <= signed_op && bus.dataA[WIDTH-1];
    end
  end

  // Divide by zero keeps the raw all-ones quotient; the remainder correction
  // still restores the original dividend.
  assign quo_final = (neg_quo && divisor != '0) ? -quo_step : quo_step;
  assign rem_final = neg_rem ? -rem_step : rem_step;
`else
  assign start        = (bus.Signal == DIVU);
  assign dividend_mag = bus.dataA;
  assign divisor_mag  = bus.dataB;
  assign quo_final    = quo_step;
  assign rem_final    = rem_step;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Only the final iteration updates the visible result.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      count   <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          rem     <= '0;
          quo     <= dividend_mag;
          divisor <= divisor_mag;
          count   <= '0;
        end
        RUN: begin
          rem   <= rem_step;
          quo   <= quo_step;
          count <= count + 6'd1;
          if (last) result <= {rem_final, quo_final};
        end
        default: ;
      endcase
    end
  end

  assign bus.dataOut = result;
endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: directed divides push expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_divider;
  import alu_ops_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];

  divider_if #(.WIDTH(32)) bus ();

  divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got dataOut 0x%016h with nothing expected", bus.dataOut);
      end else begin
        check_output("result", bus.dataOut, exp_q.pop_front());
      end
    end
  end

  // Operands are scrambled after the start edge to prove they are latched.
  task automatic apply_stimulus(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.Signal = code;
    bus.dataA  = a;
    bus.dataB  = b;
    @(negedge clk);
    bus.Signal = OUT;
    bus.dataA  = $urandom;
    bus.dataB  = $urandom;
  endtask

  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = 0;
    while (!bus.done && cycles < 100) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run_div(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    int cycles, busy_cnt;
    exp_q.push_back(exp);
    apply_stimulus(code, a, b);
    wait_done(cycles, busy_cnt);
    check_output("latency", 64'(cycles), 64'd32);
    check_output("busy_cycles", 64'(busy_cnt), 64'd32);
    check_output("busy_at_done", 64'(bus.busy), 64'd0);
  endtask

  task automatic watch_idle(input int n, output int busy_cnt, output int done_cnt);
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int cycles, busy_cnt, done_cnt;
    bus.Signal = OUT;
    bus.dataA  = '0;
    bus.dataB  = '0;
    repeat (3) @(negedge clk);
    check_output("reset_dataOut", bus.dataOut, 64'd0);
    check_output("reset_busy", 64'(bus.busy), 64'd0);
    check_output("reset_done", 64'(bus.done), 64'd0);
    reset = 1'b0;

    run_div(DIVU, 32'd100, 32'd7, 64'h00000002_0000000E);
    run_div(DIVU, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF);
    run_div(DIVU, 32'd5, 32'd9, 64'h00000005_00000000);
    run_div(DIVU, 32'h1234, 32'd0, 64'h00001234_FFFFFFFF);
    run_div(DIVU, 32'hFFFFFFFF, 32'hFFFFFFFE, 64'h00000001_00000001);

    // Start codes on iteration edges 5 and 20 must be ignored.
    exp_q.push_back(64'h00000002_0000000E);
    apply_stimulus(DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    bus.Signal = DIVU; bus.dataA = 32'd50; bus.dataB = 32'd5;
    @(negedge clk);
    bus.Signal = OUT;
    repeat (14) @(negedge clk);
    bus.Signal = DIVU; bus.dataA = 32'd50; bus.dataB = 32'd5;
    @(negedge clk);
    bus.Signal = OUT;
    wait_done(cycles, busy_cnt);
    check_output("ignored_start_latency", 64'(cycles), 64'd12);
    watch_idle(40, busy_cnt, done_cnt);
    check_output("ignored_start_no_rerun", 64'(busy_cnt), 64'd0);

    // Reset lands on iteration edge 10.
    apply_stimulus(DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("abort_dataOut", bus.dataOut, 64'd0);
    check_output("abort_busy", 64'(bus.busy), 64'd0);
    check_output("abort_done", 64'(bus.done), 64'd0);
    watch_idle(40, busy_cnt, done_cnt);
    check_output("abort_no_done", 64'(done_cnt), 64'd0);
    check_output("abort_stays_idle", 64'(busy_cnt), 64'd0);

    run_div(DIVU, 32'd9, 32'd3, 64'h00000000_00000003);

`ifdef DIVIDER_SIGNED_EN
    run_div(DIV, -32'sd7, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run_div(DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run_div(DIV, -32'sd5, 32'd0, 64'hFFFFFFFB_FFFFFFFF);
    run_div(DIVU, -32'sd7, 32'd2, 64'h00000001_7FFFFFFC);
`else
    apply_stimulus(DIV, -32'sd7, 32'd2);
    watch_idle(40, busy_cnt, done_cnt);
    check_output("div_noop_busy", 64'(busy_cnt), 64'd0);
    check_output("div_noop_done", 64'(done_cnt), 64'd0);
    check_output("div_noop_dataOut", bus.dataOut, 64'h00000000_00000003);
`endif

    repeat (5) @(negedge clk);
    check_output("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
